// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, FSM states and the data-length clamp.
// Used by the TX serializer and its parity generator.
package uart_pkg;

    localparam int MIN_DATA_W = 5;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BRK,
        ST_BRK_STOP
    } tx_state_e;

    // Number of data bits for a given length code, clamped to the widest field.
    function automatic int data_bits(input int len, input int max_w);
        int n;
        n = MIN_DATA_W + len;
        return (n > max_w) ? max_w : n;
    endfunction

endpackage

// File: rtl/uart_parity_gen.sv
// Parity over the low n_bits of data with odd/even select; par_bit is 0 when parity is off.
// Kept standalone so the receive path can reuse it.
module uart_parity_gen
    import uart_pkg::*;
#(
    parameter int DATA_W = 9,
    parameter int CNT_W  = 4
) (
    input  logic [DATA_W-1:0] data,
    input  logic [CNT_W-1:0]  n_bits,
    input  logic [1:0]        parity_type,
    output logic              par_en,
    output logic              par_bit
);

    logic [DATA_W-1:0] mask;
    logic              ones_odd;

    always_comb begin
        mask     = ~({DATA_W{1'b1}} << n_bits);
        ones_odd = ^(data & mask);
        par_en   = (parity_type == PAR_ODD) || (parity_type == PAR_EVEN);
        par_bit  = 1'b0;
        if (parity_type == PAR_ODD) begin
            par_bit = ~ones_odd;
        end else if (parity_type == PAR_EVEN) begin
            par_bit = ones_odd;
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start/data/parity/stop framing with a one-entry holding buffer.
// Optional break generation is compiled in with `define UART_TX_BREAK_EN.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_W_MAX = 9,
    parameter int LEN_W      = 3,
    parameter int BREAK_LEN  = 13
) (
    input  logic                  BaudOut,
    input  logic                  rst,
    input  logic [DATA_W_MAX-1:0] data_in,
    input  logic [LEN_W-1:0]      data_length,
    input  logic [1:0]            parity_type,
    input  logic                  stop_bits,
    input  logic                  send,
`ifdef UART_TX_BREAK_EN
    input  logic                  send_break,
`endif
    output logic                  tx_ready,
    output logic                  data_out,
    output logic                  p_parity_out,
    output logic                  tx_active,
    output logic                  tx_done
);

    localparam int CNT_MAX = (BREAK_LEN > DATA_W_MAX) ? BREAK_LEN : DATA_W_MAX;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef struct packed {
        logic [DATA_W_MAX-1:0] data;
        logic [CNT_W-1:0]      nbits;
        logic                  par_en;
        logic                  par_bit;
        logic                  stop2;
    } frame_t;

    tx_state_e             state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    frame_t                sh_q, sh_d, buf_q, buf_d, in_frame;
    logic                  buf_valid_q, buf_valid_d;
    logic                  data_out_q, data_out_d;
    logic                  tx_active_q, tx_active_d;
    logic                  tx_done_q, tx_done_d;
    logic                  last_stop, in_break, accept, frame_state;
    logic                  load_new, load_buf;
    logic                  in_par_en, in_par_bit;
    logic [CNT_W-1:0]      in_nbits;
    logic [DATA_W_MAX-1:0] shifted;

    assign in_nbits = CNT_W'(data_bits(int'(data_length), DATA_W_MAX));

    uart_parity_gen #(
        .DATA_W (DATA_W_MAX),
        .CNT_W  (CNT_W)
    ) u_parity (
        .data        (data_in),
        .n_bits      (in_nbits),
        .parity_type (parity_type),
        .par_en      (in_par_en),
        .par_bit     (in_par_bit)
    );

    always_comb begin
        in_frame.data    = data_in;
        in_frame.nbits   = in_nbits;
        in_frame.par_en  = in_par_en;
        in_frame.par_bit = in_par_bit;
        in_frame.stop2   = stop_bits;
    end

`ifdef UART_TX_BREAK_EN
    assign in_break = (state_q == ST_BRK) || (state_q == ST_BRK_STOP);
`else
    assign in_break = 1'b0;
`endif

    // The buffer slot frees on the final stop edge, so a request on that edge is taken.
    assign last_stop   = (state_q == ST_STOP) && (!sh_q.stop2 || (cnt_q == CNT_W'(1)));
    assign tx_ready    = (!buf_valid_q || last_stop) && !in_break;
    assign accept      = send && tx_ready;
    assign frame_state = (state_q == ST_START) || (state_q == ST_DATA) ||
                         (state_q == ST_PARITY) || (state_q == ST_STOP);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sh_d        = sh_q;
        buf_d       = buf_q;
        buf_valid_d = buf_valid_q;
        tx_done_d   = 1'b0;
        load_new    = 1'b0;
        load_buf    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    load_new = 1'b1;
                end
`ifdef UART_TX_BREAK_EN
                else if (send_break && !buf_valid_q) begin
                    state_d = ST_BRK;
                    cnt_d   = '0;
                end
`endif
            end
            ST_START: begin
                state_d = ST_DATA;
                cnt_d   = '0;
            end
            ST_DATA: begin
                if (cnt_q == sh_q.nbits - CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = sh_q.par_en ? ST_PARITY : ST_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_PARITY: begin
                state_d = ST_STOP;
                cnt_d   = '0;
            end
            ST_STOP: begin
                // With an empty buffer, a request on the closing edge goes straight to the shifter.
                if (last_stop) begin
                    tx_done_d = 1'b1;
                    if (buf_valid_q) begin
                        load_buf = 1'b1;
                    end else if (accept) begin
                        load_new = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef UART_TX_BREAK_EN
            ST_BRK: begin
                if (cnt_q == CNT_W'(BREAK_LEN - 1)) begin
                    state_d = ST_BRK_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_BRK_STOP: begin
                tx_done_d = 1'b1;
                state_d   = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        if (load_buf) begin
            sh_d        = buf_q;
            state_d     = ST_START;
            buf_valid_d = 1'b0;
        end
        if (load_new) begin
            sh_d    = in_frame;
            state_d = ST_START;
        end
        if (accept && !load_new) begin
            buf_d       = in_frame;
            buf_valid_d = 1'b1;
        end
    end

    // Line level is registered from the next state so the pad sees a clean flop output.
    always_comb begin
        shifted = sh_d.data >> cnt_d;
        case (state_d)
            ST_START:  data_out_d = 1'b0;
            ST_DATA:   data_out_d = shifted[0];
            ST_PARITY: data_out_d = sh_d.par_bit;
            ST_BRK:    data_out_d = 1'b0;
            default:   data_out_d = 1'b1;
        endcase
        tx_active_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge BaudOut or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            buf_valid_q <= 1'b0;
            data_out_q  <= 1'b1;
            tx_active_q <= 1'b0;
            tx_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            buf_valid_q <= buf_valid_d;
            data_out_q  <= data_out_d;
            tx_active_q <= tx_active_d;
            tx_done_q   <= tx_done_d;
        end
    end

    always_ff @(posedge BaudOut) begin
        sh_q  <= sh_d;
        buf_q <= buf_d;
    end

    assign data_out     = data_out_q;
    assign tx_active    = tx_active_q;
    assign tx_done      = tx_done_q;
    assign p_parity_out = frame_state && sh_q.par_bit;

endmodule
